xform_transpose_mac: RTL and testbench

- Sequential consumer of the per-link transform generators; used in the backward (force-propagation) pass.
- Accepts the 15 sparse spatial-transform entries of one link plus a 6-element spatial vector, and returns X^T * v.
- One shared fixed-point multiplier-accumulator runs a fixed 23-product schedule, with valid/ready handshakes on input and output.

---
 rtl/xform_transpose_mac_pkg.sv | 46 ++++
 rtl/xform_transpose_mac_fxp_mac.sv | 82 ++++++++
 rtl/xform_transpose_mac.sv | 189 ++++++++++++++++++
 tb/tb_xform_transpose_mac.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xform_transpose_mac_pkg.sv
// Shared definitions for the transpose spatial-transform MAC.
//   - Fixed-point format constants (Q.DECIMAL_BITS, ONE = 1.0).
//   - FSM state encoding.
//   - Schedule ROM encodings: operand select (the 15 stored E/L entries),
//     vector/accumulator index (AX, AY, AZ, LX, LY, LZ) and the per-step record.
package xform_transpose_mac_pkg;

  localparam int FXP_DECIMAL_BITS = 16;
  localparam int FXP_ONE          = 1 << FXP_DECIMAL_BITS;

  // Products in one X^T * v evaluation (8 E^T*vA + 7 L^T*vL + 8 E^T*vL).
  localparam int N_STEPS = 23;
  localparam int N_OPND  = 15;
  localparam int N_VEC   = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } state_e;

  // Stored matrix entries, named E/L <row><col>. E[Z][X], L[Z][Y], L[Z][Z]
  // are structurally zero and have no storage.
  typedef enum logic [3:0] {
    OP_E_XX, OP_E_XY, OP_E_XZ,
    OP_E_YX, OP_E_YY, OP_E_YZ,
    OP_E_ZY, OP_E_ZZ,
    OP_L_XX, OP_L_XY, OP_L_XZ,
    OP_L_YX, OP_L_YY, OP_L_YZ,
    OP_L_ZX
  } opnd_e;

  // Spatial-vector component index, shared by input-vector select and
  // accumulator select.
  typedef enum logic [2:0] {
    IX_AX, IX_AY, IX_AZ,
    IX_LX, IX_LY, IX_LZ
  } idx_e;

  typedef struct packed {
    opnd_e op;    // matrix entry multiplied this step
    idx_e  vsel;  // vector component it multiplies
    idx_e  asel;  // accumulator receiving the product
  } sched_t;

endpackage

// File: rtl/xform_transpose_mac_fxp_mac.sv
// fxp_mac: single shared fixed-point multiplier feeding six accumulators.
//   Stage 1 (issue_i): registers (a_i * b_i) >>> DECIMAL_BITS truncated to
//                      WIDTH, together with the target accumulator index.
//   Stage 2:           adds the registered product into accumulator sel.
//   clear_i zeroes all accumulators and drops any in-flight product.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear_i        zero accumulators
//   issue_i        launch a product of a_i * b_i into accumulator sel_i
//   a_i, b_i       signed WIDTH-bit operands
//   sel_i          accumulator index 0..5
//   acc_o          accumulators, index i at bits [i*WIDTH +: WIDTH]
module fxp_mac
  import xform_transpose_mac_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = FXP_DECIMAL_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   issue_i,
  input  logic [WIDTH-1:0]       a_i,
  input  logic [WIDTH-1:0]       b_i,
  input  logic [2:0]             sel_i,
  output logic [N_VEC*WIDTH-1:0] acc_o
);

  logic signed [2*WIDTH-1:0] prod_full;
  logic [WIDTH-1:0] prod_d, prod_q;
  logic             pv_d, pv_q;
  logic [2:0]       sel_d, sel_q;
  logic [WIDTH-1:0] acc_d [N_VEC];
  logic [WIDTH-1:0] acc_q [N_VEC];
  logic             unused_prod_bits;

  // NOTE: every always_comb output gets a default assignment first so no path
  // leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    prod_full = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) *
                $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    // Taking bits [DECIMAL_BITS +: WIDTH] of the exact product is the
    // arithmetic shift right (floor toward -inf) followed by truncation.
    prod_d = issue_i ? prod_full[DECIMAL_BITS +: WIDTH] : prod_q;
    sel_d  = issue_i ? sel_i : sel_q;
    pv_d   = issue_i && !clear_i;

    acc_d = acc_q;
    if (clear_i) begin
      for (int i = 0; i < N_VEC; i++) acc_d[i] = '0;
    end else if (pv_q) begin
      for (int i = 0; i < N_VEC; i++) begin
        if (sel_q == 3'(i)) acc_d[i] = acc_q[i] + prod_q;  // wraps, no saturation
      end
    end
  end

  assign unused_prod_bits = ^{prod_full[2*WIDTH-1:DECIMAL_BITS+WIDTH],
                              prod_full[DECIMAL_BITS-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      sel_q  <= '0;
      for (int i = 0; i < N_VEC; i++) acc_q[i] <= '0;
    end else begin
      prod_q <= prod_d;
      pv_q   <= pv_d;
      sel_q  <= sel_d;
      acc_q  <= acc_d;
    end
  end

  always_comb begin
    acc_o = '0;
    for (int i = 0; i < N_VEC; i++) acc_o[i*WIDTH +: WIDTH] = acc_q[i];
  end

endmodule

// File: rtl/xform_transpose_mac.sv
// xform_transpose_mac: computes X^T * v for one link's sparse spatial
// transform X = [E 0; L E] on a single shared MAC, 23 products in ROM order.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid / in_ready           operand handshake (ready only when idle)
//   xform_in_*                    15 stored E / L entries
//   vec_in_*                      input spatial vector
//   out_valid / out_ready         result handshake
//   vec_out_*                     result; holds the last result between ops
module xform_transpose_mac
  import xform_transpose_mac_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DECIMAL_BITS = FXP_DECIMAL_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] xform_in_AX_AX, xform_in_AX_AY, xform_in_AX_AZ,
  input  logic [WIDTH-1:0] xform_in_AY_AX, xform_in_AY_AY, xform_in_AY_AZ,
  input  logic [WIDTH-1:0] xform_in_AZ_AY, xform_in_AZ_AZ,
  input  logic [WIDTH-1:0] xform_in_LX_AX, xform_in_LX_AY, xform_in_LX_AZ,
  input  logic [WIDTH-1:0] xform_in_LY_AX, xform_in_LY_AY, xform_in_LY_AZ,
  input  logic [WIDTH-1:0] xform_in_LZ_AX,
  input  logic [WIDTH-1:0] vec_in_AX, vec_in_AY, vec_in_AZ,
  input  logic [WIDTH-1:0] vec_in_LX, vec_in_LY, vec_in_LZ,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] vec_out_AX, vec_out_AY, vec_out_AZ,
  output logic [WIDTH-1:0] vec_out_LX, vec_out_LY, vec_out_LZ
);

  state_e                  state_d, state_q;
  logic [4:0]              step_d, step_q;
  logic [WIDTH-1:0]        opnd_d [N_OPND];
  logic [WIDTH-1:0]        opnd_q [N_OPND];
  logic [WIDTH-1:0]        vec_d  [N_VEC];
  logic [WIDTH-1:0]        vec_q  [N_VEC];
  logic [WIDTH-1:0]        held_d [N_VEC];
  logic [WIDTH-1:0]        held_q [N_VEC];
  logic [WIDTH-1:0]        result [N_VEC];
  logic                    accept, issue, handoff;
  sched_t                  sched;
  logic [N_VEC*WIDTH-1:0]  acc_flat;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // ---- FSM: next state ----
  // The multiplier output is registered, so the last product (step 22) lands
  // in its accumulator one cycle after issue; MAC therefore runs to step 23.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_MAC;
        step_d  = '0;
      end
      ST_MAC: begin
        if (step_q == 5'(N_STEPS)) begin
          state_d = ST_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    accept    = in_valid && in_ready;
    handoff   = out_valid && out_ready;
    issue     = (state_q == ST_MAC) && (step_q < 5'(N_STEPS));
  end

  // ---- Schedule ROM ----
  always_comb begin
    sched = '{OP_E_XX, IX_AX, IX_AX};
    unique case (step_q)
      5'd0:  sched = '{OP_E_XX, IX_AX, IX_AX};  // E^T * v_A -> A
      5'd1:  sched = '{OP_E_XY, IX_AX, IX_AY};
      5'd2:  sched = '{OP_E_XZ, IX_AX, IX_AZ};
      5'd3:  sched = '{OP_E_YX, IX_AY, IX_AX};
      5'd4:  sched = '{OP_E_YY, IX_AY, IX_AY};
      5'd5:  sched = '{OP_E_YZ, IX_AY, IX_AZ};
      5'd6:  sched = '{OP_E_ZY, IX_AZ, IX_AY};
      5'd7:  sched = '{OP_E_ZZ, IX_AZ, IX_AZ};
      5'd8:  sched = '{OP_L_XX, IX_LX, IX_AX};  // L^T * v_L -> A
      5'd9:  sched = '{OP_L_XY, IX_LX, IX_AY};
      5'd10: sched = '{OP_L_XZ, IX_LX, IX_AZ};
      5'd11: sched = '{OP_L_YX, IX_LY, IX_AX};
      5'd12: sched = '{OP_L_YY, IX_LY, IX_AY};
      5'd13: sched = '{OP_L_YZ, IX_LY, IX_AZ};
      5'd14: sched = '{OP_L_ZX, IX_LZ, IX_AX};
      5'd15: sched = '{OP_E_XX, IX_LX, IX_LX};  // E^T * v_L -> L
      5'd16: sched = '{OP_E_XY, IX_LX, IX_LY};
      5'd17: sched = '{OP_E_XZ, IX_LX, IX_LZ};
      5'd18: sched = '{OP_E_YX, IX_LY, IX_LX};
      5'd19: sched = '{OP_E_YY, IX_LY, IX_LY};
      5'd20: sched = '{OP_E_YZ, IX_LY, IX_LZ};
      5'd21: sched = '{OP_E_ZY, IX_LZ, IX_LY};
      5'd22: sched = '{OP_E_ZZ, IX_LZ, IX_LZ};
      default: ;
    endcase
  end

  // ---- Operand capture ----
  always_comb begin
    opnd_d = opnd_q;
    vec_d  = vec_q;
    if (accept) begin
      opnd_d[OP_E_XX] = xform_in_AX_AX;  opnd_d[OP_E_XY] = xform_in_AX_AY;
      opnd_d[OP_E_XZ] = xform_in_AX_AZ;  opnd_d[OP_E_YX] = xform_in_AY_AX;
      opnd_d[OP_E_YY] = xform_in_AY_AY;  opnd_d[OP_E_YZ] = xform_in_AY_AZ;
      opnd_d[OP_E_ZY] = xform_in_AZ_AY;  opnd_d[OP_E_ZZ] = xform_in_AZ_AZ;
      opnd_d[OP_L_XX] = xform_in_LX_AX;  opnd_d[OP_L_XY] = xform_in_LX_AY;
      opnd_d[OP_L_XZ] = xform_in_LX_AZ;  opnd_d[OP_L_YX] = xform_in_LY_AX;
      opnd_d[OP_L_YY] = xform_in_LY_AY;  opnd_d[OP_L_YZ] = xform_in_LY_AZ;
      opnd_d[OP_L_ZX] = xform_in_LZ_AX;
      vec_d[IX_AX] = vec_in_AX;  vec_d[IX_AY] = vec_in_AY;  vec_d[IX_AZ] = vec_in_AZ;
      vec_d[IX_LX] = vec_in_LX;  vec_d[IX_LY] = vec_in_LY;  vec_d[IX_LZ] = vec_in_LZ;
    end
  end

  // NOTE: operand registers carry no reset; they are written on every accept
  // before MAC reads them, so reset would only cost routing.
  always_ff @(posedge clk) begin
    opnd_q <= opnd_d;
    vec_q  <= vec_d;
  end

  fxp_mac #(
    .WIDTH        (WIDTH),
    .DECIMAL_BITS (DECIMAL_BITS)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (accept),
    .issue_i (issue),
    .a_i     (opnd_q[sched.op]),
    .b_i     (vec_q[sched.vsel]),
    .sel_i   (sched.asel),
    .acc_o   (acc_flat)
  );

  // ---- Result presentation ----
  // During DONE the accumulators drive the outputs directly; the handoff
  // copies them into held_q so the value survives the next op's clear.
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < N_VEC; i++) begin
      if (handoff) held_d[i] = acc_flat[i*WIDTH +: WIDTH];
      result[i] = out_valid ? acc_flat[i*WIDTH +: WIDTH] : held_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_VEC; i++) held_q[i] <= '0;
    end else begin
      held_q <= held_d;
    end
  end

  always_comb begin
    vec_out_AX = result[IX_AX];
    vec_out_AY = result[IX_AY];
    vec_out_AZ = result[IX_AZ];
    vec_out_LX = result[IX_LX];
    vec_out_LY = result[IX_LY];
    vec_out_LZ = result[IX_LZ];
  end

endmodule

// File: tb/tb_xform_transpose_mac.sv
// Self-checking bench for xform_transpose_mac: directed table, random ops
// against a 6x6 matrix reference model, backpressure and mid-op reset.
module tb_xform_transpose_mac;
  import xform_transpose_mac_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] xform_in_AX_AX, xform_in_AX_AY, xform_in_AX_AZ;
  logic [W-1:0] xform_in_AY_AX, xform_in_AY_AY, xform_in_AY_AZ;
  logic [W-1:0] xform_in_AZ_AY, xform_in_AZ_AZ;
  logic [W-1:0] xform_in_LX_AX, xform_in_LX_AY, xform_in_LX_AZ;
  logic [W-1:0] xform_in_LY_AX, xform_in_LY_AY, xform_in_LY_AZ, xform_in_LZ_AX;
  logic [W-1:0] vec_in_AX, vec_in_AY, vec_in_AZ, vec_in_LX, vec_in_LY, vec_in_LZ;
  logic [W-1:0] vec_out_AX, vec_out_AY, vec_out_AZ, vec_out_LX, vec_out_LY, vec_out_LZ;

  always #5 clk = ~clk;

  xform_transpose_mac #(.WIDTH(W), .DECIMAL_BITS(FXP_DECIMAL_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xform_in_AX_AX(xform_in_AX_AX), .xform_in_AX_AY(xform_in_AX_AY),
    .xform_in_AX_AZ(xform_in_AX_AZ), .xform_in_AY_AX(xform_in_AY_AX),
    .xform_in_AY_AY(xform_in_AY_AY), .xform_in_AY_AZ(xform_in_AY_AZ),
    .xform_in_AZ_AY(xform_in_AZ_AY), .xform_in_AZ_AZ(xform_in_AZ_AZ),
    .xform_in_LX_AX(xform_in_LX_AX), .xform_in_LX_AY(xform_in_LX_AY),
    .xform_in_LX_AZ(xform_in_LX_AZ), .xform_in_LY_AX(xform_in_LY_AX),
    .xform_in_LY_AY(xform_in_LY_AY), .xform_in_LY_AZ(xform_in_LY_AZ),
    .xform_in_LZ_AX(xform_in_LZ_AX),
    .vec_in_AX(vec_in_AX), .vec_in_AY(vec_in_AY), .vec_in_AZ(vec_in_AZ),
    .vec_in_LX(vec_in_LX), .vec_in_LY(vec_in_LY), .vec_in_LZ(vec_in_LZ),
    .out_valid(out_valid), .out_ready(out_ready),
    .vec_out_AX(vec_out_AX), .vec_out_AY(vec_out_AY), .vec_out_AZ(vec_out_AZ),
    .vec_out_LX(vec_out_LX), .vec_out_LY(vec_out_LY), .vec_out_LZ(vec_out_LZ)
  );

  // e/l indexed [row][col] with 0=X,1=Y,2=Z; v = (AX,AY,AZ,LX,LY,LZ).
  typedef struct packed {
    logic [2:0][2:0][W-1:0] e;
    logic [2:0][2:0][W-1:0] l;
    logic [5:0][W-1:0]      v;
  } ops_t;

  typedef struct {
    string             name;
    ops_t              ops;
    logic [5:0][W-1:0] expv;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [5:0][W-1:0] cur_out();
    cur_out = {vec_out_LZ, vec_out_LY, vec_out_LX, vec_out_AZ, vec_out_AY, vec_out_AX};
  endfunction

  task automatic drive_ops(input ops_t o);
    xform_in_AX_AX = o.e[0][0]; xform_in_AX_AY = o.e[0][1]; xform_in_AX_AZ = o.e[0][2];
    xform_in_AY_AX = o.e[1][0]; xform_in_AY_AY = o.e[1][1]; xform_in_AY_AZ = o.e[1][2];
    xform_in_AZ_AY = o.e[2][1]; xform_in_AZ_AZ = o.e[2][2];
    xform_in_LX_AX = o.l[0][0]; xform_in_LX_AY = o.l[0][1]; xform_in_LX_AZ = o.l[0][2];
    xform_in_LY_AX = o.l[1][0]; xform_in_LY_AY = o.l[1][1]; xform_in_LY_AZ = o.l[1][2];
    xform_in_LZ_AX = o.l[2][0];
    vec_in_AX = o.v[0]; vec_in_AY = o.v[1]; vec_in_AZ = o.v[2];
    vec_in_LX = o.v[3]; vec_in_LY = o.v[4]; vec_in_LZ = o.v[5];
  endtask

  function automatic logic [W-1:0] rnd_word();
    if ($urandom_range(1) == 0) rnd_word = $urandom;
    else rnd_word = W'($urandom_range(0, 8 * FXP_ONE)) - W'(4 * FXP_ONE);
  endfunction

  function automatic ops_t rand_ops();
    ops_t o;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        o.e[r][c] = rnd_word();
        o.l[r][c] = rnd_word();
      end
    for (int i = 0; i < 6; i++) o.v[i] = rnd_word();
    o.e[2][0] = '0; o.l[2][1] = '0; o.l[2][2] = '0;
    return o;
  endfunction

  // Reference: build X = [E 0; L E] as a dense 6x6 matrix and evaluate
  // out[c] = sum_r trunc((X[r][c] * v[r]) >>> DECIMAL_BITS), wrapping in 32 bits.
  function automatic logic [5:0][W-1:0] model(input ops_t o);
    int x[6][6];
    int vv[6];
    logic [5:0][W-1:0] res;
    for (int r = 0; r < 6; r++) begin
      vv[r] = int'(o.v[r]);
      for (int c = 0; c < 6; c++) x[r][c] = 0;
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        x[r][c]         = int'(o.e[r][c]);
        x[r + 3][c]     = int'(o.l[r][c]);
        x[r + 3][c + 3] = int'(o.e[r][c]);
      end
    x[2][0] = 0; x[5][3] = 0;             // E[Z][X] structurally zero
    x[5][1] = 0; x[5][2] = 0;             // L[Z][Y], L[Z][Z] structurally zero
    for (int c = 0; c < 6; c++) begin
      int acc = 0;
      for (int r = 0; r < 6; r++) begin
        longint p = longint'(x[r][c]) * longint'(vv[r]);
        acc += int'(p >>> FXP_DECIMAL_BITS);
      end
      res[c] = acc;
    end
    return res;
  endfunction

  // Call at a negedge. Returns at the negedge where out_valid is first seen,
  // with lat = clock edges from the accepting edge.
  task automatic run_op(input ops_t o, output logic [5:0][W-1:0] res, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    drive_ops(o);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    drive_ops(rand_ops());  // operands are don't-care after the accept
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = cur_out();
  endtask

  vec_t tbl[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0][W-1:0] res, mdl;
    int   lat;
    ops_t op_b;
    bit   seen;

    // ---- Directed table ----
    tbl[0].name = "link9";
    tbl[0].ops  = '0;
    tbl[0].ops.e[0][0] = W'(-FXP_ONE);
    tbl[0].ops.e[1][2] = W'(FXP_ONE);
    tbl[0].ops.e[2][1] = W'(FXP_ONE);
    tbl[0].ops.l[0][2] = W'(5308);
    tbl[0].ops.l[1][0] = W'(5308);
    tbl[0].ops.v[3]    = W'(FXP_ONE);
    tbl[0].expv = '0;
    tbl[0].expv[2] = W'(5308);
    tbl[0].expv[3] = 32'hFFFF_0000;

    tbl[1].name = "identity";
    tbl[1].ops  = '0;
    tbl[1].ops.e[0][0] = W'(FXP_ONE);
    tbl[1].ops.e[1][1] = W'(FXP_ONE);
    tbl[1].ops.e[2][2] = W'(FXP_ONE);
    for (int i = 0; i < 6; i++) tbl[1].ops.v[i] = W'((i + 1) * FXP_ONE);
    tbl[1].expv = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
                   32'h0003_0000, 32'h0002_0000, 32'h0001_0000};

    tbl[2].name = "neg_floor";
    tbl[2].ops  = '0;
    tbl[2].ops.e[0][0] = W'(-32768);
    tbl[2].ops.v[0]    = W'(3);
    tbl[2].expv = '0;
    tbl[2].expv[0] = 32'hFFFF_FFFE;

    tbl[3].name = "wrap";
    tbl[3].ops  = '0;
    tbl[3].ops.e[0][0] = W'(FXP_ONE);
    tbl[3].ops.e[1][0] = W'(FXP_ONE);
    tbl[3].ops.v[0]    = 32'h7FFF_0000;
    tbl[3].ops.v[1]    = 32'h7FFF_0000;
    tbl[3].expv = '0;
    tbl[3].expv[0] = 32'hFFFE_0000;

    drive_ops('0);

    // ---- Reset state ----
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    res = cur_out();
    for (int i = 0; i < 6; i++) check($sformatf("reset_out[%0d]", i), res[i], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- Table-driven vectors ----
    for (int k = 0; k < 4; k++) begin
      run_op(tbl[k].ops, res, lat);
      check({tbl[k].name, "_latency"}, lat, 24);
      check({tbl[k].name, "_in_ready_done"}, in_ready, 0);
      for (int i = 0; i < 6; i++)
        check($sformatf("%s_out[%0d]", tbl[k].name, i), res[i], tbl[k].expv[i]);
      @(negedge clk);  // handoff edge passed with out_ready high
      check({tbl[k].name, "_valid_drop"}, out_valid, 0);
      res = cur_out();
      check({tbl[k].name, "_retain_AX"}, res[0], tbl[k].expv[0]);
    end

    // ---- Random ops vs reference model ----
    for (int n = 0; n < 20; n++) begin
      ops_t o = rand_ops();
      mdl = model(o);
      run_op(o, res, lat);
      check($sformatf("rand%0d_latency", n), lat, 24);
      for (int i = 0; i < 6; i++) check($sformatf("rand%0d_out[%0d]", n, i), res[i], mdl[i]);
      @(negedge clk);
      check($sformatf("rand%0d_valid_drop", n), out_valid, 0);
    end

    // ---- Backpressure with a competing request ----
    out_ready = 1'b0;
    run_op(tbl[1].ops, res, lat);
    check("bp_latency", lat, 24);
    op_b = rand_ops();
    drive_ops(op_b);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", c), out_valid, 1);
      check($sformatf("bp_hold%0d_in_ready", c), in_ready, 0);
      res = cur_out();
      for (int i = 0; i < 6; i++)
        check($sformatf("bp_hold%0d_out[%0d]", c, i), res[i], tbl[1].expv[i]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_handoff_valid", out_valid, 0);
    check("bp_handoff_in_ready", in_ready, 1);
    res = cur_out();
    for (int i = 0; i < 6; i++) check($sformatf("bp_retain_out[%0d]", i), res[i], tbl[1].expv[i]);
    mdl = model(op_b);
    run_op(op_b, res, lat);
    check("bp_second_latency", lat, 24);
    for (int i = 0; i < 6; i++) check($sformatf("bp_second_out[%0d]", i), res[i], mdl[i]);
    @(negedge clk);

    // ---- Reset asserted mid-MAC ----
    drive_ops(rand_ops());
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    res = cur_out();
    for (int i = 0; i < 6; i++) check($sformatf("midrst_out[%0d]", i), res[i], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_partial_valid", seen, 0);
    begin
      ops_t o = rand_ops();
      mdl = model(o);
      run_op(o, res, lat);
      check("postrst_latency", lat, 24);
      for (int i = 0; i < 6; i++) check($sformatf("postrst_out[%0d]", i), res[i], mdl[i]);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
